// File: rtl/fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl
//
// Instruction-fetch sequencer. Owns the program counter and runs a simple,
// non-pipelined instruction-memory request/response handshake. Each fetch takes
// a REQ cycle, one or more WAIT cycles, and one delivery cycle.
//
// Redirect sources, highest priority first:
//   misaligned taken branch, aligned taken branch, ecall, ebreak,
//   memory-misalign trap.
// A redirect moves the PC to its target and kills any fetch still in flight.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, the block adds two free-running 32-bit counters:
//   o_fetch_cnt (instructions consumed by decode) and o_flush_cnt (flush pulses).
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_stall                decode cannot accept; hold the delivered instruction
//   i_branch_taken/_addr   resolved taken branch and its target
//   i_trap                 trap code (E_CALL / E_BREAK / MEM_MISALIGN, else none)
//   o_imem_req/_addr       fetch request and address
//   i_imem_ready           memory accepts the request this cycle
//   i_imem_valid/_rdata    memory response
//   o_instr_valid/_instr/_instr_pc  instruction delivered to decode
//   o_flush                one-cycle pulse: younger pipeline state is invalid
//   o_branch_misaligned    one-cycle pulse on a misaligned-branch redirect
//   o_fetch_cnt, o_flush_cnt  (FETCH_PERF_CNT_EN only) performance counters
// -----------------------------------------------------------------------------

`ifndef E_CALL
`define E_CALL 2'b01
`endif
`ifndef E_BREAK
`define E_BREAK 2'b10
`endif
`ifndef MEM_MISALIGN
`define MEM_MISALIGN 2'b11
`endif

module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter logic [31:0] MISALIGN_VEC = 32'd1020,
  parameter logic [31:0] ECALL_VEC    = 32'd2050,
  parameter logic [31:0] EBREAK_VEC   = 32'd2051,
  parameter logic [31:0] MEMMIS_VEC   = 32'd2052
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  input  logic [1:0]  i_trap,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_flush,
  output logic        o_branch_misaligned
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] issued_pc;
  logic [31:0] issued_pc_next;
  logic        instr_valid_next;
  logic [31:0] instr_next;
  logic [31:0] instr_pc_next;

  logic        branch_misaligned;
  logic        trap_hit;
  logic        redirect;
  logic [31:0] redirect_target;

  // A taken branch always beats a simultaneous trap; the trap is simply
  // dropped and its source has to raise it again if it is still pending.
  always_comb begin
    branch_misaligned = i_branch_taken && (i_branch_addr[1:0] != 2'b00);
    trap_hit          = 1'b0;
    redirect_target   = pc;
    if (branch_misaligned) begin
      redirect_target = MISALIGN_VEC;
    end else if (i_branch_taken) begin
      redirect_target = i_branch_addr;
    end else if (i_trap == `E_CALL) begin
      trap_hit        = 1'b1;
      redirect_target = ECALL_VEC;
    end else if (i_trap == `E_BREAK) begin
      trap_hit        = 1'b1;
      redirect_target = EBREAK_VEC;
    end else if (i_trap == `MEM_MISALIGN) begin
      trap_hit        = 1'b1;
      redirect_target = MEMMIS_VEC;
    end
    // IDLE is the settling cycle after reset; redirects are not honoured there.
    redirect = (state != S_IDLE) && (i_branch_taken || trap_hit);
  end

  // Next-state logic. A redirect overrides everything, including a stall.
  // When a redirect lands on a fetch the memory has already accepted, the
  // sequencer parks in DRAIN until that orphaned response turns up.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    issued_pc_next   = issued_pc;
    instr_valid_next = 1'b0;
    instr_next       = o_instr;
    instr_pc_next    = o_instr_pc;

    case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = i_imem_ready ? S_DRAIN : S_REQ;
        end else if (i_imem_ready) begin
          issued_pc_next = pc;
          state_next     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = i_imem_valid ? S_REQ : S_DRAIN;
        end else if (i_imem_valid) begin
          instr_next       = i_imem_rdata;
          instr_pc_next    = issued_pc;
          instr_valid_next = 1'b1;
          pc_next          = issued_pc + 32'd4;
          state_next       = i_stall ? S_HOLD : S_REQ;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (i_stall) begin
          instr_valid_next = 1'b1;
        end else begin
          state_next = S_REQ;
        end
      end

      S_DRAIN: begin
        // If the orphaned response arrives together with another redirect
        // there is nothing left to wait for, so go straight back to REQ.
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = i_imem_valid ? S_REQ : S_DRAIN;
        end else if (i_imem_valid) begin
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= S_IDLE;
      pc                  <= RESET_ADDR;
      issued_pc           <= RESET_ADDR;
      o_instr_valid       <= 1'b0;
      o_instr             <= 32'd0;
      o_instr_pc          <= 32'd0;
      o_flush             <= 1'b0;
      o_branch_misaligned <= 1'b0;
    end else begin
      state               <= state_next;
      pc                  <= pc_next;
      issued_pc           <= issued_pc_next;
      o_instr_valid       <= instr_valid_next;
      o_instr             <= instr_next;
      o_instr_pc          <= instr_pc_next;
      o_flush             <= redirect;
      o_branch_misaligned <= redirect && branch_misaligned;
    end
  end

  assign o_imem_req  = (state == S_REQ);
  assign o_imem_addr = pc;

`ifdef FETCH_PERF_CNT_EN
  // Consumption is any cycle decode sees a valid instruction and is not stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else begin
      if (o_instr_valid && !i_stall) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (o_flush) begin
        o_flush_cnt <= o_flush_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq_ctrl
//
// Directed bench for fetch_seq_ctrl. A small memory model answers each accepted
// request two cycles after acceptance with data = address ^ KEY. Expected
// request addresses, delivered instructions and flush pulses are pushed into
// queues by the stimulus; independent monitors pop and compare them whenever
// the DUT presents the corresponding event.
// -----------------------------------------------------------------------------

`ifndef E_CALL
`define E_CALL 2'b01
`endif
`ifndef E_BREAK
`define E_BREAK 2'b10
`endif
`ifndef MEM_MISALIGN
`define MEM_MISALIGN 2'b11
`endif

module tb_fetch_seq_ctrl;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [1:0]  trap;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        flush;
  logic        branch_mis;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_seq_ctrl dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_stall             (stall),
    .i_branch_taken      (branch_taken),
    .i_branch_addr       (branch_addr),
    .i_trap              (trap),
    .o_imem_req          (imem_req),
    .o_imem_addr         (imem_addr),
    .i_imem_ready        (imem_ready),
    .i_imem_valid        (imem_valid),
    .i_imem_rdata        (imem_rdata),
    .o_instr_valid       (instr_valid),
    .o_instr             (instr),
    .o_instr_pc          (instr_pc),
    .o_flush             (flush),
    .o_branch_misaligned (branch_mis)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt         (fetch_cnt),
    .o_flush_cnt         (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_pres_q[$];
  logic        exp_flush_q[$];

  logic        acc_flag = 1'b0;
  logic [31:0] acc_addr = 32'd0;
  int          mem_cd = 0;
  logic [31:0] mem_addr = 32'd0;

  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] held_pc = 32'd0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportMissing(input string name, input logic [31:0] actual);
    total++;
    bad++;
    $display("[TB] FAIL %s: got event %0h with no expectation queued at %0t", name, actual, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Drives one cycle of inputs. On entry rst still holds the previous
  // cycle's value, which is what the memory model needs to see.
  task automatic applyStimulus(input int c);
    logic stale;
    stale = 1'b0;

    if (rst) mem_cd = 0;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    if (mem_cd == 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem_addr ^ KEY;
      mem_cd     = 0;
    end
    if (acc_flag) begin
      mem_cd   = 1;
      mem_addr = acc_addr;
    end

    rst          = (c < 0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    trap         = 2'b00;
    imem_ready   = 1'b1;

    case (c)
      -3: begin
        exp_req_q.push_back(32'h0);  exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h8);  exp_req_q.push_back(32'hC);
        exp_req_q.push_back(32'h10);
        exp_pres_q.push_back(32'h0); exp_pres_q.push_back(32'h4);
        exp_pres_q.push_back(32'h8); exp_pres_q.push_back(32'hC);
      end
      9, 10, 11, 12, 13: stall = 1'b1;
      19: begin
        branch_taken = 1'b1; branch_addr = 32'h100;
        exp_req_q.push_back(32'h100); exp_req_q.push_back(32'h104);
        exp_req_q.push_back(32'h108);
        exp_pres_q.push_back(32'h100); exp_pres_q.push_back(32'h104);
        exp_flush_q.push_back(1'b0);
      end
      27: begin
        branch_taken = 1'b1; branch_addr = 32'h102;
        exp_req_q.push_back(32'd1020); exp_req_q.push_back(32'd1024);
        exp_pres_q.push_back(32'd1020);
        exp_flush_q.push_back(1'b1);
      end
      34: begin
        branch_taken = 1'b1; branch_addr = 32'h40; trap = `E_CALL;
        exp_req_q.push_back(32'h40); exp_req_q.push_back(32'h44);
        exp_pres_q.push_back(32'h40);
        exp_flush_q.push_back(1'b0);
      end
      41: begin
        trap = `E_BREAK;
        exp_req_q.push_back(32'd2051);
        exp_pres_q.push_back(32'd2051);
        exp_flush_q.push_back(1'b0);
      end
      45: begin
        imem_ready = 1'b0; trap = `MEM_MISALIGN;
        exp_req_q.push_back(32'd2052); exp_req_q.push_back(32'd2056);
        exp_pres_q.push_back(32'd2052); exp_pres_q.push_back(32'd2056);
        exp_flush_q.push_back(1'b0);
      end
      51: stall = 1'b1;
      52: begin
        stall = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
        exp_req_q.push_back(32'h200); exp_req_q.push_back(32'h204);
        exp_pres_q.push_back(32'h200);
        exp_flush_q.push_back(1'b0);
      end
      57: begin
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        exp_req_q.push_back(32'hFFFF_FFFC); exp_req_q.push_back(32'h0);
        exp_pres_q.push_back(32'hFFFF_FFFC);
        exp_flush_q.push_back(1'b0);
      end
      63: begin
        rst = 1'b1;
        exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h8);
        exp_pres_q.push_back(32'h0); exp_pres_q.push_back(32'h4);
      end
      64, 65: begin
        rst = 1'b1; stale = 1'b1;
      end
      default: ;
    endcase

    if (stale) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  // Request monitor: every accepted request must match the next expected address.
  always @(negedge clk) begin
    acc_flag = 1'b0;
    if (!rst && imem_req && imem_ready) begin
      acc_flag = 1'b1;
      acc_addr = imem_addr;
      if (exp_req_q.size() == 0) reportMissing("req_addr", imem_addr);
      else checkOutput("req_addr", {96'd0, imem_addr}, {96'd0, exp_req_q.pop_front()});
    end
  end

  // Delivery monitor: a new presentation pops the queue; a stalled hold must
  // keep the same instruction and must not issue a request.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (instr_valid) begin
        if (prev_valid && prev_stall) begin
          checkOutput("held_pc", {96'd0, instr_pc}, {96'd0, held_pc});
          checkOutput("held_instr", {96'd0, instr}, {96'd0, held_pc ^ KEY});
        end else if (exp_pres_q.size() == 0) begin
          reportMissing("instr_pc", instr_pc);
        end else begin
          held_pc = exp_pres_q.pop_front();
          checkOutput("instr_pc", {96'd0, instr_pc}, {96'd0, held_pc});
          checkOutput("instr", {96'd0, instr}, {96'd0, held_pc ^ KEY});
        end
        if (stall) checkOutput("hold_no_req", {127'd0, imem_req}, 128'd0);
      end
      prev_valid = instr_valid;
      prev_stall = stall;
    end
  end

  // Flush monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        if (exp_flush_q.size() == 0) reportMissing("flush", {31'd0, branch_mis});
        else checkOutput("flush_misaligned", {127'd0, branch_mis},
                         {127'd0, exp_flush_q.pop_front()});
      end else if (branch_mis) begin
        reportMissing("misaligned_without_flush", 32'd1);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    trap         = 2'b00;
    imem_ready   = 1'b1;
    imem_valid   = 1'b0;
    imem_rdata   = 32'd0;

    for (int c = -3; c <= 75; c++) begin
      if (c == 0 || c == 65 || c == 66) begin
        checkOutput("reset_outputs",
                    {28'd0, imem_req, imem_addr, instr_valid, instr, instr_pc, flush, branch_mis},
                    128'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("reset_counters", {64'd0, fetch_cnt, flush_cnt}, 128'd0);
`endif
      end
      applyStimulus(c);
      tick;
    end

    checkOutput("req_queue_drained", 128'(exp_req_q.size()), 128'd0);
    checkOutput("instr_queue_drained", 128'(exp_pres_q.size()), 128'd0);
    checkOutput("flush_queue_drained", 128'(exp_flush_q.size()), 128'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetch_cnt_after_reset", {96'd0, fetch_cnt}, {96'd0, 32'd2});
    checkOutput("flush_cnt_after_reset", {96'd0, flush_cnt}, 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
